// File: rtl/awg_cmd_ctrl.sv
// AWG control-state registers driven by the UART byte stream: decimal arguments followed by a
// command letter set waveform, frequency, amplitude and phase; sweep_tick steps the frequency.
module awg_cmd_ctrl #(
  parameter int unsigned NUM_WAVES  = 5,
  parameter int unsigned SEL_W      = 5,
  parameter int unsigned FREQ_W     = 12,
  parameter int unsigned FREQ_MIN   = 1,
  parameter int unsigned FREQ_MAX   = 4095,
  parameter int unsigned FREQ_DEF   = 1,
  parameter int unsigned SWEEP_STEP = 100,
  parameter int unsigned AMP_W      = 3,
  parameter int unsigned AMP_MAX    = 7,
  parameter int unsigned AMP_DEF    = 4,
  parameter int unsigned PHASE_W    = 8,
  parameter int unsigned PHASE_DEF  = 50,
  parameter int unsigned ACC_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         cmd,
  input  logic               rd,
  input  logic               sweep_tick,
  output logic [SEL_W-1:0]   wave_sel,
  output logic [FREQ_W-1:0]  freq_word,
  output logic [AMP_W-1:0]   amp_sel,
  output logic [PHASE_W-1:0] phase_off,
  output logic               sweep_en,
  output logic               cmd_ok,
  output logic               cmd_err
);

  localparam int unsigned MulW = ACC_W + 4;
  localparam int unsigned SumW = FREQ_W + 1;
  localparam logic [MulW-1:0] AccLim = {4'b0000, {ACC_W{1'b1}}};

  localparam logic [7:0] ChF = 8'h46;
  localparam logic [7:0] ChA = 8'h41;
  localparam logic [7:0] ChP = 8'h50;
  localparam logic [7:0] ChW = 8'h57;
  localparam logic [7:0] ChWInc = 8'h77;
  localparam logic [7:0] ChS = 8'h53;
  localparam logic [7:0] ChX = 8'h78;

  typedef enum logic {StIdle, StAccum} state_e;

  state_e            state_q;
  logic [ACC_W-1:0]  acc_q;
  logic              rd_meta_q, rd_sync_q, rd_dly_q;

  logic              byte_stb;
  logic              is_digit;
  logic [MulW-1:0]   acc_mul;
  logic              acc_sat;
  logic [FREQ_W-1:0] freq_clamp;
  logic [AMP_W-1:0]  amp_clamp;
  logic              wave_ok;
  logic [SEL_W-1:0]  wave_inc;
  logic [SumW-1:0]   sweep_sum;
  logic [FREQ_W-1:0] sweep_next;
  logic              freq_load;

  always_comb begin
    byte_stb   = rd_sync_q & ~rd_dly_q;
    is_digit   = (cmd >= 8'h30) && (cmd <= 8'h39);
    acc_mul    = ({4'b0000, acc_q} * MulW'(10)) + MulW'(cmd[3:0]);
    acc_sat    = acc_mul > AccLim;

    if (acc_q < ACC_W'(FREQ_MIN)) begin
      freq_clamp = FREQ_W'(FREQ_MIN);
    end else if (acc_q > ACC_W'(FREQ_MAX)) begin
      freq_clamp = FREQ_W'(FREQ_MAX);
    end else begin
      freq_clamp = acc_q[FREQ_W-1:0];
    end

    amp_clamp  = (acc_q > ACC_W'(AMP_MAX)) ? AMP_W'(AMP_MAX) : acc_q[AMP_W-1:0];
    wave_ok    = acc_q < ACC_W'(NUM_WAVES);
    wave_inc   = (wave_sel == SEL_W'(NUM_WAVES - 1)) ? '0 : wave_sel + 1'b1;

    // Sum kept one bit wider so the FREQ_MAX compare sees the carry.
    sweep_sum  = {1'b0, freq_word} + SumW'(SWEEP_STEP);
    sweep_next = (sweep_sum > SumW'(FREQ_MAX)) ? FREQ_W'(FREQ_DEF) : sweep_sum[FREQ_W-1:0];

    // An accepted 'F' owns freq_word this cycle; a coincident sweep tick is dropped.
    freq_load  = byte_stb && (state_q == StAccum) && (cmd == ChF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_meta_q <= 1'b0;
      rd_sync_q <= 1'b0;
      rd_dly_q  <= 1'b0;
      state_q   <= StIdle;
      acc_q     <= '0;
      wave_sel  <= '0;
      freq_word <= FREQ_W'(FREQ_DEF);
      amp_sel   <= AMP_W'(AMP_DEF);
      phase_off <= PHASE_W'(PHASE_DEF);
      sweep_en  <= 1'b0;
      cmd_ok    <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      rd_meta_q <= rd;
      rd_sync_q <= rd_meta_q;
      rd_dly_q  <= rd_sync_q;
      cmd_ok    <= 1'b0;
      cmd_err   <= 1'b0;

      if (sweep_en && sweep_tick && !freq_load) begin
        freq_word <= sweep_next;
      end

      if (byte_stb) begin
        if (is_digit) begin
          acc_q   <= acc_sat ? {ACC_W{1'b1}} : acc_mul[ACC_W-1:0];
          cmd_err <= acc_sat;
          state_q <= StAccum;
        end else begin
          acc_q   <= '0;
          state_q <= StIdle;
          case (cmd)
            ChF: begin
              if (state_q == StAccum) begin
                freq_word <= freq_clamp;
                cmd_ok    <= 1'b1;
              end else begin
                cmd_err   <= 1'b1;
              end
            end
            ChA: begin
              if (state_q == StAccum) begin
                amp_sel <= amp_clamp;
                cmd_ok  <= 1'b1;
              end else begin
                cmd_err <= 1'b1;
              end
            end
            ChP: begin
              if (state_q == StAccum) begin
                phase_off <= acc_q[PHASE_W-1:0];
                cmd_ok    <= 1'b1;
              end else begin
                cmd_err   <= 1'b1;
              end
            end
            ChW: begin
              if ((state_q == StAccum) && wave_ok) begin
                wave_sel <= acc_q[SEL_W-1:0];
                cmd_ok   <= 1'b1;
              end else begin
                cmd_err  <= 1'b1;
              end
            end
            ChWInc: begin
              if (state_q == StIdle) begin
                wave_sel <= wave_inc;
                cmd_ok   <= 1'b1;
              end else begin
                cmd_err  <= 1'b1;
              end
            end
            ChS: begin
              if (state_q == StIdle) begin
                sweep_en <= ~sweep_en;
                cmd_ok   <= 1'b1;
              end else begin
                cmd_err  <= 1'b1;
              end
            end
            ChX:     cmd_ok  <= 1'b1;
            default: cmd_err <= 1'b1;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_awg_cmd_ctrl.sv
// Scoreboard bench for awg_cmd_ctrl: directed byte stream with hand-computed expected state,
// checked by a monitor whenever the DUT pulses cmd_ok/cmd_err or a sweep tick is applied.
module tb_awg_cmd_ctrl;

  localparam int KNone = 0;
  localparam int KOk   = 1;
  localparam int KErr  = 2;
  localparam int KTick = 3;

  typedef struct {
    int kind;
    int cyc;
    int wave;
    int freq;
    int amp;
    int phase;
    int sweep;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cmd;
  logic       rd;
  logic       sweep_tick;
  logic [4:0] wave_sel;
  logic [11:0] freq_word;
  logic [2:0] amp_sel;
  logic [7:0] phase_off;
  logic       sweep_en;
  logic       cmd_ok;
  logic       cmd_err;

  int   cyc = 0;
  logic tick_seen = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  // Hand-maintained expected register state, set by the directed sequence below.
  int e_wave, e_freq, e_amp, e_phase, e_sweep;

  awg_cmd_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .rd         (rd),
    .sweep_tick (sweep_tick),
    .wave_sel   (wave_sel),
    .freq_word  (freq_word),
    .amp_sel    (amp_sel),
    .phase_off  (phase_off),
    .sweep_en   (sweep_en),
    .cmd_ok     (cmd_ok),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    tick_seen <= sweep_tick;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind  = kind;
    e.cyc   = at;
    e.wave  = e_wave;
    e.freq  = e_freq;
    e.amp   = e_amp;
    e.phase = e_phase;
    e.sweep = e_sweep;
    sbq.push_back(e);
  endtask

  // tk raises sweep_tick in the cycle the byte strobe is decoded.
  task automatic send(input logic [7:0] b, input int kind, input bit tk = 1'b0,
                      input int hold = 4);
    @(negedge clk);
    cmd = b;
    rd  = 1'b1;
    if (kind != KNone) push(kind, cyc + 3);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      sweep_tick = tk && (i == 1);
    end
    rd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic dig(input int d);
    send(8'(8'h30 + d), KNone);
  endtask

  task automatic tick();
    @(negedge clk);
    sweep_tick = 1'b1;
    push(KTick, cyc + 1);
    @(negedge clk);
    sweep_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic set_defaults();
    e_wave = 0; e_freq = 1; e_amp = 4; e_phase = 50; e_sweep = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, " wave_sel"}, int'(wave_sel), e_wave);
    check({tag, " freq_word"}, int'(freq_word), e_freq);
    check({tag, " amp_sel"}, int'(amp_sel), e_amp);
    check({tag, " phase_off"}, int'(phase_off), e_phase);
    check({tag, " sweep_en"}, int'(sweep_en), e_sweep);
    check({tag, " pulses"}, int'({cmd_ok, cmd_err}), 0);
  endtask

  // Monitor: pops one expectation per response the DUT presents.
  always @(negedge clk) begin
    if (rst_n && (cmd_ok || cmd_err || tick_seen)) begin
      if (cmd_ok && cmd_err) check("ok_err_exclusive", 1, 0);
      if (sbq.size() == 0) begin
        check("unexpected_response", int'({cmd_ok, cmd_err, tick_seen}), 0);
      end else begin
        exp_t e;
        int   kind;
        e    = sbq.pop_front();
        kind = cmd_ok ? KOk : (cmd_err ? KErr : KTick);
        check("response_kind", kind, e.kind);
        check("response_cycle", cyc, e.cyc);
        check("wave_sel", int'(wave_sel), e.wave);
        check("freq_word", int'(freq_word), e.freq);
        check("amp_sel", int'(amp_sel), e.amp);
        check("phase_off", int'(phase_off), e.phase);
        check("sweep_en", int'(sweep_en), e.sweep);
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; rd = 1'b0; cmd = 8'h00; sweep_tick = 1'b0;
    set_defaults();
    repeat (3) @(negedge clk);
    check_state("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // T1: decimal frequency, latency checked by the monitor
    dig(1); dig(2); dig(3);
    e_freq = 123; send("F", KOk);

    // T2: amplitude clamp, phase wrap
    dig(9); dig(9);
    e_amp = 7; send("A", KOk);
    dig(3); dig(0); dig(0);
    e_phase = 44; send("P", KOk);

    // T3: wave increment wraps; out-of-range W rejected
    for (int i = 1; i <= 5; i++) begin
      e_wave = i % 5; send("w", KOk);
    end
    dig(7); send("W", KErr);

    // T4: sweep with wrap to FREQ_DEF, command beats a coincident tick
    dig(4); dig(0); dig(0); dig(0);
    e_freq = 4000; send("F", KOk);
    e_sweep = 1; send("S", KOk);
    e_freq = 1;   tick();
    e_freq = 101; tick();
    e_freq = 201; tick();
    dig(5); dig(0); dig(0);
    e_freq = 500; send("F", KOk, 1'b1);
    e_freq = 600; tick();
    e_sweep = 0; send("S", KOk);
    tick();

    // T5: error paths, accumulator saturation, min clamp, 'x', wrap of phase
    dig(5); send("S", KErr);
    send("A", KErr);
    for (int i = 0; i < 4; i++) dig(9);
    send("9", KErr);
    send("9", KErr);
    e_freq = 4095; send("F", KOk);
    dig(0);
    e_freq = 1; send("F", KOk);
    dig(7); send("x", KOk);
    send("W", KErr);
    dig(2);
    e_wave = 2; send("W", KOk);
    send("z", KErr);
    dig(3); send("w", KErr);
    dig(3);
    e_amp = 3; send("A", KOk);
    dig(2); dig(5); dig(6);
    e_phase = 0; send("P", KOk);

    // T6: long rd level gives one strobe; reset discards a partial argument
    e_wave = 3; send("w", KOk, 1'b0, 20);
    dig(4);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    set_defaults();
    check_state("mid_cmd_reset");
    check("queue_empty_at_reset", sbq.size(), 0);
    rst_n = 1'b1;
    send("F", KErr);

    repeat (10) @(negedge clk);
    check("queue_empty_at_end", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
